// File: rtl/display_scanner_if.sv
// Signal bundle between the display scanner and its host/decoder side.
// The master modport loads data and picks up the scanned digit; the slave is the scanner.
interface display_scanner_if;
   logic        load;
   logic [15:0] dataIn;
   logic        blankLz;
   logic [3:0]  nOut;
   logic [3:0]  anOut;
   logic        pending;
   logic        frameDone;

   modport master (
      output load, dataIn, blankLz,
      input  nOut, anOut, pending, frameDone
   );

   modport slave (
      input  load, dataIn, blankLz,
      output nOut, anOut, pending, frameDone
   );
endinterface

// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment scanner with a shadow register.
// New data is committed only at frame boundaries, so a frame never mixes old and new digits.
module display_scanner #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input logic              clk,
   input logic              rst,
   display_scanner_if.slave bus
);
   localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);

   logic [15:0] presc;
   logic [1:0]  index;
   logic [15:0] display;
   logic [15:0] shadow;
   logic        pending_q;
   logic        frame_q;
   logic        tick;
   logic        frame_edge;
   logic        lz1, lz2, lz3;
   logic        blanked;

   assign tick       = (presc == LAST);
   assign frame_edge = tick && (index == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc     <= '0;
         index     <= '0;
         display   <= '0;
         shadow    <= '0;
         pending_q <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         presc   <= tick ? '0 : presc + 16'd1;
         frame_q <= frame_edge;
         if (tick)
            index <= index + 2'd1;
         if (frame_edge && pending_q)
            display <= shadow;
         // A load on the commit edge wins over the clear: the fresh shadow is still owed a frame.
         if (bus.load) begin
            shadow    <= bus.dataIn;
            pending_q <= 1'b1;
         end else if (frame_edge) begin
            pending_q <= 1'b0;
         end
      end
   end

   // lzK: display digits K..3 are all zero
   always_comb begin
      lz3     = (display[15:12] == 4'h0);
      lz2     = lz3 && (display[11:8] == 4'h0);
      lz1     = lz2 && (display[7:4] == 4'h0);
      blanked = 1'b0;
      unique case (index)
         2'd1:    blanked = bus.blankLz && lz1;
         2'd2:    blanked = bus.blankLz && lz2;
         2'd3:    blanked = bus.blankLz && lz3;
         default: blanked = 1'b0;
      endcase
   end

   assign bus.nOut      = display[{index, 2'b00} +: 4];
   assign bus.anOut     = blanked ? '1 : ~(4'b0001 << index);
   assign bus.pending   = pending_q;
   assign bus.frameDone = frame_q;
endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner at REFRESH_DIV=4: each frame start queues the
// four expected digit slots, which are compared every cycle and retired as each digit ends.
module tb_display_scanner;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   display_scanner_if bus();

   display_scanner #(.REFRESH_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] disp;
      int unsigned k;
   } slot_t;

   slot_t       sb[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          c      = 0;
   logic [15:0] m_disp;
   logic [15:0] m_shadow;
   logic        m_pend;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, c, got, exp);
      end
   endtask

   function automatic logic [3:0] exp_an(input logic [15:0] d, input int unsigned k, input logic bl);
      logic [3:0] one;
      one = 4'b0001;
      if (bl && k != 0 && (d >> (4 * k)) == 16'h0)
         return 4'b1111;
      return ~(one << k);
   endfunction

   task automatic monitor();
      slot_t s;
      logic [15:0] d;
      if (c % 16 == 0)
         for (int unsigned k = 0; k < 4; k++)
            sb.push_back('{disp: m_disp, k: k});
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_empty (cycle %0d): got 0 entries, expected at least 1", c);
         return;
      end
      s = sb[0];
      d = s.disp >> (4 * s.k);
      check("anOut", 32'(bus.anOut), 32'(exp_an(s.disp, s.k, bus.blankLz)));
      check("nOut", 32'(bus.nOut), 32'(d[3:0]));
      check("pending", 32'(bus.pending), 32'(m_pend));
      check("frameDone", 32'(bus.frameDone), 32'((c % 16 == 0) && (c > 0)));
      if (c % 4 == 3)
         void'(sb.pop_front());
   endtask

   task automatic tick_clk();
      logic [15:0] old_sh;
      logic        old_p;
      @(posedge clk);
      c++;
      old_sh = m_shadow;
      old_p  = m_pend;
      if (bus.load) begin
         m_shadow = bus.dataIn;
         m_pend   = 1'b1;
      end
      if (c % 16 == 0 && old_p) begin
         m_disp = old_sh;
         if (!bus.load)
            m_pend = 1'b0;
      end
      @(negedge clk);
      monitor();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++)
         tick_clk();
   endtask

   task automatic run_to(input int phase);
      for (int i = 0; i < 64; i++) begin
         if (c % 16 == phase)
            return;
         tick_clk();
      end
      check("run_to_timeout", 32'(c % 16), 32'(phase));
   endtask

   task automatic do_load(input logic [15:0] data);
      bus.dataIn = data;
      bus.load   = 1'b1;
      tick_clk();
      bus.load   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_anOut"}, 32'(bus.anOut), 32'h E);
      check({tag, "_nOut"}, 32'(bus.nOut), 32'h0);
      check({tag, "_pending"}, 32'(bus.pending), 32'h0);
      check({tag, "_frameDone"}, 32'(bus.frameDone), 32'h0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_now");
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_hold");
      m_disp   = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      c        = 0;
      sb.delete();
      rst = 1'b0;
      monitor();
   endtask

   initial begin
      rst         = 1'b1;
      bus.load    = 1'b0;
      bus.dataIn  = '0;
      bus.blankLz = 1'b0;

      // Idle scan after reset: zeros, 4 cycles per digit, frameDone every 16
      reset_dut();
      run(32);

      // Mid-frame load is held back until the boundary
      run_to(6);
      do_load(16'h12AB);
      run_to(0);
      run(16);

      // Leading-zero blanking, including same-cycle response to blankLz
      do_load(16'h0050);
      run_to(0);
      bus.blankLz = 1'b1;
      run(16);
      run_to(12);
      bus.blankLz = 1'b0;
      #1 check("blank_off_now", 32'(bus.anOut), 32'h7);
      bus.blankLz = 1'b1;
      #1 check("blank_on_now", 32'(bus.anOut), 32'hF);
      run(4);
      bus.blankLz = 1'b0;
      run(16);

      // Second load in the same frame overwrites the shadow
      run_to(2);
      do_load(16'h1111);
      run(3);
      do_load(16'h2222);
      run_to(0);
      run(16);

      // Load on the commit edge: 4444 shown next, 3333 the frame after
      run_to(4);
      do_load(16'h4444);
      run_to(15);
      do_load(16'h3333);
      run(32);

      // Reset during digit 2 with data pending discards it
      run_to(3);
      do_load(16'hBEEF);
      run_to(9);
      reset_dut();
      run(32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
